// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants, types and helpers for the instruction fetch queue.
// Pointer widths are derived from the row count through row_w().
package inst_fetch_queue_pkg;

   localparam int unsigned IFQ_ROWS_DEFAULT = 4;
   localparam int unsigned LINE_BYTES       = 16;
   localparam int unsigned WORDS_PER_LINE   = 4;
   localparam int unsigned WORD_SEL_W       = 2;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] line_t;

   function automatic word_t line_align(input word_t addr);
      return {addr[31:4], 4'b0000};
   endfunction

   function automatic int unsigned row_w(input int unsigned rows);
      return $clog2(rows);
   endfunction

endpackage

// File: rtl/ifq_checker.sv
// Protocol checks for the fetch queue: the cache must never return a line
// while the queue is full (no request is outstanding then).
module ifq_checker (
   input logic Clk,
   input logic Resetb,
   input logic Cache_ReadHit,
   input logic Ifetch_ReadCache
);

   a_no_hit_when_full: assert property (@(posedge Clk) disable iff (!Resetb)
      !(Cache_ReadHit && !Ifetch_ReadCache));

endmodule

// File: rtl/ifq_line_ram.sv
// ROWS x 128-bit line store: one synchronous write port and a
// combinational word read. Contents are intentionally not reset.
module ifq_line_ram
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned ROWS = IFQ_ROWS_DEFAULT
)
(
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [row_w(ROWS)-1:0]  wr_row,
   input  line_t                   wr_data,
   input  logic [row_w(ROWS)-1:0]  rd_row,
   input  logic [WORD_SEL_W-1:0]   rd_word,
   output word_t                   rd_data
);

   line_t mem_q [ROWS];
   line_t rd_line_s;

   // line write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_row] <= wr_data;
      end
   end

   // word select from the addressed row
   always_comb begin
      rd_line_s = mem_q[rd_row];
      case (rd_word)
         2'd0:    rd_data = rd_line_s[31:0];
         2'd1:    rd_data = rd_line_s[63:32];
         2'd2:    rd_data = rd_line_s[95:64];
         2'd3:    rd_data = rd_line_s[127:96];
         default: rd_data = rd_line_s[31:0];
      endcase
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: requests line-aligned cache reads, queues the
// returned lines in a circular row buffer and presents the head to dispatch.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned ROWS = IFQ_ROWS_DEFAULT
)
(
   input  logic        Clk,
   input  logic        Resetb,
   output logic [31:0] Ifetch_WpPcIn,
   output logic        Ifetch_ReadCache,
   output logic        IFQ_Flush,
   input  logic [31:0] Cache_Cd0,
   input  logic [31:0] Cache_Cd1,
   input  logic [31:0] Cache_Cd2,
   input  logic [31:0] Cache_Cd3,
   input  logic        Cache_ReadHit,
   input  logic        Dis_Ren,
   input  logic        Dis_JmpBrAddrValid,
   input  logic [31:0] Dis_JmpBrAddr,
   output logic [31:0] Ifetch_Instruction,
   output logic [31:0] Ifetch_PcPlusFour,
   output logic        Ifetch_EmptyFlag
);

   localparam int unsigned ROW_W = row_w(ROWS);

   // wp = {wrap, row}; rp = {wrap, row, word}
   logic [ROW_W:0]   wp_q, wp_d;
   logic [ROW_W+2:0] rp_q, rp_d;
   word_t            pc_q, pc_d;
   word_t            head_pc_q, head_pc_d;

   logic empty_s;
   logic full_s;
   logic wr_en_s;
   logic rd_en_s;

   assign empty_s = (rp_q[ROW_W+2:2] == wp_q);
   assign full_s  = (rp_q[ROW_W+2] != wp_q[ROW_W]) &&
                    (rp_q[ROW_W+1:2] == wp_q[ROW_W-1:0]);

   // a flush wins over both a returning line and a dispatch read
   assign wr_en_s = Cache_ReadHit & ~Dis_JmpBrAddrValid & ~full_s;
   assign rd_en_s = Dis_Ren & ~Dis_JmpBrAddrValid & ~empty_s;

   // next-state for pointers and PCs
   always_comb begin
      pc_d      = pc_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      head_pc_d = head_pc_q;
      if (Dis_JmpBrAddrValid) begin
         pc_d      = line_align(Dis_JmpBrAddr);
         wp_d      = '0;
         rp_d      = '0;
         rp_d[1:0] = Dis_JmpBrAddr[3:2];
         head_pc_d = Dis_JmpBrAddr;
      end else begin
         if (wr_en_s) begin
            wp_d = wp_q + (ROW_W+1)'(1);
            pc_d = pc_q + 32'd16;
         end else begin
            wp_d = wp_q;
            pc_d = pc_q;
         end
         if (rd_en_s) begin
            rp_d      = rp_q + (ROW_W+3)'(1);
            head_pc_d = head_pc_q + 32'd4;
         end else begin
            rp_d      = rp_q;
            head_pc_d = head_pc_q;
         end
      end
   end

   // state registers, synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Resetb) begin
         pc_q      <= 32'd0;
         wp_q      <= '0;
         rp_q      <= '0;
         head_pc_q <= 32'd0;
      end else begin
         pc_q      <= pc_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         head_pc_q <= head_pc_d;
      end
   end

   ifq_line_ram #(.ROWS(ROWS)) u_line_ram (
      .clk     (Clk),
      .wr_en   (wr_en_s),
      .wr_row  (wp_q[ROW_W-1:0]),
      .wr_data ({Cache_Cd3, Cache_Cd2, Cache_Cd1, Cache_Cd0}),
      .rd_row  (rp_q[ROW_W+1:2]),
      .rd_word (rp_q[1:0]),
      .rd_data (Ifetch_Instruction)
   );

   ifq_checker u_checker (
      .Clk              (Clk),
      .Resetb           (Resetb),
      .Cache_ReadHit    (Cache_ReadHit),
      .Ifetch_ReadCache (Ifetch_ReadCache)
   );

   assign Ifetch_WpPcIn     = line_align(pc_q);
   assign Ifetch_ReadCache  = ~full_s;
   assign IFQ_Flush         = Dis_JmpBrAddrValid;
   assign Ifetch_PcPlusFour = head_pc_q + 32'd4;
   assign Ifetch_EmptyFlag  = empty_s;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: a line-queue reference model and a
// one-outstanding-request cache model drive and predict every cycle.
module tb_inst_fetch_queue;

   localparam int ROWS = 4;

   logic        Clk = 1'b0;
   logic        Resetb;
   logic [31:0] Ifetch_WpPcIn;
   logic        Ifetch_ReadCache;
   logic        IFQ_Flush;
   logic [31:0] Cache_Cd0, Cache_Cd1, Cache_Cd2, Cache_Cd3;
   logic        Cache_ReadHit;
   logic        Dis_Ren;
   logic        Dis_JmpBrAddrValid;
   logic [31:0] Dis_JmpBrAddr;
   logic [31:0] Ifetch_Instruction;
   logic [31:0] Ifetch_PcPlusFour;
   logic        Ifetch_EmptyFlag;

   always #5 Clk = ~Clk;

   inst_fetch_queue #(.ROWS(ROWS)) dut (
      .Clk                (Clk),
      .Resetb             (Resetb),
      .Ifetch_WpPcIn      (Ifetch_WpPcIn),
      .Ifetch_ReadCache   (Ifetch_ReadCache),
      .IFQ_Flush          (IFQ_Flush),
      .Cache_Cd0          (Cache_Cd0),
      .Cache_Cd1          (Cache_Cd1),
      .Cache_Cd2          (Cache_Cd2),
      .Cache_Cd3          (Cache_Cd3),
      .Cache_ReadHit      (Cache_ReadHit),
      .Dis_Ren            (Dis_Ren),
      .Dis_JmpBrAddrValid (Dis_JmpBrAddrValid),
      .Dis_JmpBrAddr      (Dis_JmpBrAddr),
      .Ifetch_Instruction (Ifetch_Instruction),
      .Ifetch_PcPlusFour  (Ifetch_PcPlusFour),
      .Ifetch_EmptyFlag   (Ifetch_EmptyFlag)
   );

   int checks = 0;
   int errors = 0;

   // reference model: whole lines in arrival order plus head word offset
   logic [31:0]  m_pc;
   logic [31:0]  m_head_pc;
   logic [127:0] m_lines[$];
   int           m_off;

   // cache model: one outstanding request
   bit           c_busy;
   logic [127:0] c_line;
   int           c_cnt;
   int           lat;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'd0;
      m_head_pc = 32'd0;
      m_lines.delete();
      m_off     = 0;
      c_busy    = 1'b0;
   endtask

   task automatic check_outputs();
      check_eq("empty", Ifetch_EmptyFlag, m_lines.size() == 0);
      check_eq("readcache", Ifetch_ReadCache, m_lines.size() < ROWS);
      check_eq("wppcin", Ifetch_WpPcIn, {m_pc[31:4], 4'b0000});
      check_eq("pcplus4", Ifetch_PcPlusFour, m_head_pc + 32'd4);
      if (m_lines.size() != 0)
         check_eq("instr", Ifetch_Instruction, m_lines[0][m_off*32 +: 32]);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Resetb             = 1'b0;
      Cache_ReadHit      = 1'b0;
      Dis_Ren            = 1'b0;
      Dis_JmpBrAddrValid = 1'b0;
      Dis_JmpBrAddr      = 32'd0;
      model_reset();
      @(negedge Clk);
      Resetb = 1'b1;
      check_eq("rst_empty", Ifetch_EmptyFlag, 32'd1);
      check_eq("rst_readcache", Ifetch_ReadCache, 32'd1);
      check_eq("rst_wppcin", Ifetch_WpPcIn, 32'd0);
      check_eq("rst_flush", IFQ_Flush, 32'd0);
      check_eq("rst_pcplus4", Ifetch_PcPlusFour, 32'd4);
   endtask

   // one clock: check, drive, predict; returns just after the rising edge
   task automatic cycle(input bit fl, input logic [31:0] tgt, input bit ren, input bit hit_ok);
      bit hit;
      bit was_busy;
      bit was_empty;
      @(negedge Clk);
      check_outputs();
      hit      = c_busy && (c_cnt == 0) && hit_ok;
      was_busy = c_busy;
      if (c_busy && c_cnt > 0) c_cnt--;
      Dis_JmpBrAddrValid = fl;
      Dis_JmpBrAddr      = tgt;
      Dis_Ren            = ren;
      Cache_ReadHit      = hit;
      Cache_Cd0 = hit ? c_line[31:0]   : $urandom;
      Cache_Cd1 = hit ? c_line[63:32]  : $urandom;
      Cache_Cd2 = hit ? c_line[95:64]  : $urandom;
      Cache_Cd3 = hit ? c_line[127:96] : $urandom;
      if (!was_busy && m_lines.size() < ROWS) begin
         c_busy = 1'b1;
         c_line = {$urandom, $urandom, $urandom, $urandom};
         c_cnt  = lat;
      end
      #1;
      check_eq("flush", IFQ_Flush, fl);
      if (fl) begin
         m_lines.delete();
         m_off     = int'(tgt[3:2]);
         m_head_pc = tgt;
         m_pc      = {tgt[31:4], 4'b0000};
         c_busy    = 1'b0;
      end else begin
         was_empty = (m_lines.size() == 0);
         if (ren && !was_empty) begin
            m_head_pc += 32'd4;
            if (m_off == 3) begin
               void'(m_lines.pop_front());
               m_off = 0;
            end else begin
               m_off++;
            end
         end
         if (hit) begin
            m_lines.push_back(c_line);
            m_pc  += 32'd16;
            c_busy = 1'b0;
         end
      end
      @(posedge Clk);
      #1;
      Cache_ReadHit      = 1'b0;
      Dis_Ren            = 1'b0;
      Dis_JmpBrAddrValid = 1'b0;
   endtask

   initial begin
      logic [31:0] first_word;
      Resetb             = 1'b0;
      Cache_ReadHit      = 1'b0;
      Dis_Ren            = 1'b0;
      Dis_JmpBrAddrValid = 1'b0;
      Dis_JmpBrAddr      = 32'd0;
      Cache_Cd0 = 32'd0; Cache_Cd1 = 32'd0; Cache_Cd2 = 32'd0; Cache_Cd3 = 32'd0;
      lat = 1;
      model_reset();

      // fill to full with no reads
      do_reset();
      repeat (24) cycle(1'b0, 32'd0, 1'b0, 1'b1);
      first_word = (m_lines.size() != 0) ? m_lines[0][31:0] : 32'hDEAD_BEEF;
      check_eq("full_readcache", Ifetch_ReadCache, 32'd0);
      check_eq("full_wppcin", Ifetch_WpPcIn, 32'h40);
      check_eq("full_empty", Ifetch_EmptyFlag, 32'd0);
      check_eq("full_pcplus4", Ifetch_PcPlusFour, 32'd4);
      check_eq("full_head", Ifetch_Instruction, first_word);

      // drain all 16 words; hold the refill request back
      repeat (16) cycle(1'b0, 32'd0, 1'b1, 1'b0);
      check_eq("drain_empty", Ifetch_EmptyFlag, 32'd1);
      check_eq("drain_pcplus4", Ifetch_PcPlusFour, 32'h44);
      check_eq("drain_readcache", Ifetch_ReadCache, 32'd1);
      repeat (4) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // flush to 0x128 with a concurrent hit
      do_reset();
      lat = 0;
      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0128, 1'b0, 1'b1);
      check_eq("flush_wppcin", Ifetch_WpPcIn, 32'h120);
      check_eq("flush_empty", Ifetch_EmptyFlag, 32'd1);
      repeat (3) cycle(1'b0, 32'd0, 1'b0, 1'b1);
      check_eq("flush_pcplus4", Ifetch_PcPlusFour, 32'h12C);
      check_eq("flush_notempty", Ifetch_EmptyFlag, 32'd0);

      // simultaneous hits and reads at shallow depth
      repeat (40) cycle(1'b0, 32'd0, 1'b1, 1'b1);

      // reset in the middle of a fill
      lat = 1;
      repeat (5) cycle(1'b0, 32'd0, 1'b0, 1'b1);
      do_reset();

      // randomized traffic
      repeat (3000) begin
         lat = $urandom_range(0, 3);
         if ($urandom_range(0, 499) == 0)
            do_reset();
         cycle($urandom_range(0, 39) == 0, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
